// File: rtl/obi_pkg.sv
// Shared OBI bus payload types and the copy-master FSM state encoding.
package obi_pkg;

    localparam int unsigned OBI_ADDR_W     = 32;
    localparam int unsigned OBI_DATA_W     = 32;
    localparam int unsigned OBI_BE_W       = OBI_DATA_W / 8;
    localparam int unsigned OBI_WORD_BYTES = 4;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_ADDR_W-1:0] addr;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } obi_copy_state_e;

endpackage

// File: rtl/obi_copy_perf_cnt.sv
// Saturating busy-cycle counter for the copy master, cleared on each accepted start.
module obi_copy_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        en_i,
    output logic [31:0] cycles_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycles_o <= '0;
        end else if (clear_i) begin
            cycles_o <= '0;
        end else if (en_i && (cycles_o != 32'hFFFF_FFFF)) begin
            cycles_o <= cycles_o + 32'd1;
        end
    end

endmodule

// File: rtl/obi_copy_master.sv
// OBI initiator copying len_i words from src to dst, one transaction at a time.
// Optional busy-cycle counter output cycles_o under OBI_COPY_MASTER_PERF_CNT_EN.
module obi_copy_master
    import obi_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
`ifdef OBI_COPY_MASTER_PERF_CNT_EN
    output logic [31:0]          cycles_o,
`endif
    output obi_req_t             obi_req_o,
    input  obi_resp_t            obi_resp_i
);

    obi_copy_state_e      state_q, state_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [31:0]          data_q, data_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    obi_req_t             req_q, req_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next state, datapath and registered-output pre-computation.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        len_d   = len_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d   = src_addr_i & ~32'h3;
                    dst_d   = dst_addr_i & ~32'h3;
                    len_d   = len_i;
                    cnt_d   = '0;
                    state_d = (len_i == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                if (obi_resp_i.gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (obi_resp_i.rvalid) begin
                    data_d  = obi_resp_i.rdata;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (obi_resp_i.gnt) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (obi_resp_i.rvalid) begin
                    src_d   = src_q + 32'(OBI_WORD_BYTES);
                    dst_d   = dst_q + 32'(OBI_WORD_BYTES);
                    cnt_d   = cnt_q + LEN_WIDTH'(1);
                    state_d = (cnt_d == len_q) ? DONE : RD_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Request fields follow the state being entered so they are stable from its first cycle.
        req_d = '0;
        if (state_d == RD_REQ) begin
            req_d.req  = 1'b1;
            req_d.be   = '1;
            req_d.addr = src_d;
        end else if (state_d == WR_REQ) begin
            req_d.req   = 1'b1;
            req_d.we    = 1'b1;
            req_d.be    = '1;
            req_d.addr  = dst_d;
            req_d.wdata = data_d;
        end

        busy_d = (state_d == RD_REQ) || (state_d == RD_WAIT) ||
                 (state_d == WR_REQ) || (state_d == WR_WAIT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            req_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign obi_req_o = req_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

`ifdef OBI_COPY_MASTER_PERF_CNT_EN
    logic start_acc_c;
    assign start_acc_c = (state_q == IDLE) && start_i;

    obi_copy_perf_cnt u_perf_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (start_acc_c),
        .en_i     (busy_q),
        .cycles_o (cycles_o)
    );
`endif

endmodule
